// File: rtl/sr_flip_flop.sv
// sr_flip_flop: WIDTH independent edge-triggered SR lanes with a registered s=r=1 flag
module sr_flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] invalid
);
    logic [WIDTH-1:0] q_d, q_q, invalid_d, invalid_q;
    // next state: set wins only alone, clear only alone, both or neither hold and 11 raises invalid
    always_comb begin
        q_d       = rst ? '0 : (s & ~r) | (q_q & ~(r & ~s));
        invalid_d = rst ? '0 : s & r;
    end
    // state register, reset sampled on the clock edge
    always_ff @(posedge clk) begin
        q_q       <= q_d;
        invalid_q <= invalid_d;
    end
    assign q       = q_q;
    assign q_bar   = ~q_q;
    assign invalid = invalid_q;
endmodule

// File: tb/tb_sr_flip_flop.sv
// tb_sr_flip_flop: directed and random checks of a 4-lane sr_flip_flop against a lane-wise table model
module tb_sr_flip_flop;
    localparam int W = 4;
    logic         clk = 0;
    logic         rst = 0;
    logic [W-1:0] s = '0;
    logic [W-1:0] r = '0;
    logic [W-1:0] q, q_bar, invalid;
    logic [W-1:0] mq, mi;
    int           n_assert = 0;
    int           n_fail = 0;

    sr_flip_flop #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .q_bar(q_bar), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        n_assert++;
        assert (q === mq) else begin
            n_fail++;
            $error("FAIL %s q observed=%b expected=%b", tag, q, mq);
        end
        n_assert++;
        assert (q_bar === ~mq) else begin
            n_fail++;
            $error("FAIL %s q_bar observed=%b expected=%b", tag, q_bar, ~mq);
        end
        n_assert++;
        assert (invalid === mi) else begin
            n_fail++;
            $error("FAIL %s invalid observed=%b expected=%b", tag, invalid, mi);
        end
    endtask

    // model: per lane, 00 hold, 01 clear, 10 set, 11 hold + flag; reset clears everything
    task automatic model_edge(input logic rv, input logic [W-1:0] sv, input logic [W-1:0] cv);
        if (rv) begin
            mq = '0;
            mi = '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                mi[i] = sv[i] && cv[i];
                if (sv[i] && !cv[i]) mq[i] = 1'b1;
                if (!sv[i] && cv[i]) mq[i] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic rv, input logic [W-1:0] sv, input logic [W-1:0] cv,
                        input string tag, input logic pre);
        @(negedge clk);
        rst = rv;
        s   = sv;
        r   = cv;
        #1;
        if (pre) check({tag, "_pre_edge"});
        @(posedge clk);
        model_edge(rv, sv, cv);
        #1;
        check(tag);
    endtask

    initial begin
        mq = '0;
        mi = '0;
        step(1'b1, 4'b1111, 4'b0000, "reset_prio", 1'b0);
        step(1'b0, 4'b0000, 4'b0000, "idle_after_reset", 1'b1);
        step(1'b0, 4'b1111, 4'b0000, "set", 1'b1);
        step(1'b0, 4'b0000, 4'b1111, "clear", 1'b1);
        step(1'b0, 4'b0000, 4'b0000, "hold0", 1'b1);
        step(1'b0, 4'b1111, 4'b0000, "set_again", 1'b1);
        step(1'b0, 4'b1111, 4'b1111, "both_hold1", 1'b1);
        step(1'b0, 4'b0000, 4'b0000, "invalid_clear", 1'b1);
        step(1'b1, 4'b1111, 4'b0000, "rst_over_set", 1'b1);
        step(1'b1, 4'b1010, 4'b0101, "rst_held", 1'b1);
        step(1'b0, 4'b0000, 4'b0000, "resume", 1'b1);
        @(negedge clk);
        s = 4'b1111;
        #1;
        check("s_pulse_high");
        s = 4'b0000;
        #1;
        check("s_pulse_low");
        @(posedge clk);
        model_edge(1'b0, 4'b0000, 4'b0000);
        #1;
        check("after_pulse");
        step(1'b0, 4'b0101, 4'b0011, "lane_mix", 1'b1);
        step(1'b0, 4'b0011, 4'b0011, "lane_both", 1'b1);
        for (int k = 0; k < 300; k++)
            step(($urandom_range(15) == 0), W'($urandom), W'($urandom), "random", 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
